conv_psum_accum: RTL

//  Downstream of the PIM conv crossbar stage. Consumes one ADC_P-bit column result per address for each of IN_BITS input bit-slices (LSB first).

---
 rtl/conv_psum_accum_pkg.sv | 29 ++
 rtl/conv_psum_accum_if.sv | 35 +++
 rtl/conv_psum_accum_rf.sv | 28 ++
 rtl/conv_psum_accum.sv | 136 +++++++++++++
 4 files changed

// File: rtl/conv_psum_accum_pkg.sv
// Shared types and helpers for the conv partial-sum accumulator.
// State encoding, address-width function and default sizes.
package conv_psum_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int clogb2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEPTH_DEF   = 32;
  localparam int ADC_P_DEF   = 8;
  localparam int IN_BITS_DEF = 8;
  localparam int ACC_W_DEF   = 16;
  localparam int AW_DEF      = clogb2(DEPTH_DEF);

endpackage

// File: rtl/conv_psum_accum_if.sv
// Input beat / output stream bundle of the psum accumulator.
// master drives stimulus and ready, slave is the accumulator.
interface conv_psum_accum_if
  import conv_psum_accum_pkg::*;
#(
  parameter int ADC_P = ADC_P_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int AW    = AW_DEF
);
  logic             start;
  logic             in_valid;
  logic [ADC_P-1:0] in_data;
  logic [AW-1:0]    in_addr;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [AW-1:0]    out_addr;
  logic             done;
  logic             err;

  modport master (
    output start, in_valid, in_data,
    output in_addr, out_ready,
    input  busy, out_valid, out_data,
    input  out_addr, done, err
  );

  modport slave (
    input  start, in_valid, in_data,
    input  in_addr, out_ready,
    output busy, out_valid, out_data,
    output out_addr, done, err
  );
endinterface

// File: rtl/conv_psum_accum_rf.sv
// DEPTH x ACC_W accumulator file: one write port that either
// overwrites or adds to the stored value, one drain read port.
module conv_psum_accum_rf #(
  parameter int DEPTH = 32,
  parameter int ACC_W = 16,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             add_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [ACC_W-1:0] wd_i,
  input  logic [AW-1:0]    ra_i,
  output logic [ACC_W-1:0] rd_o
);
  logic [ACC_W-1:0] mem_q [0:DEPTH-1];
  logic [ACC_W-1:0] opnd;

  assign opnd = mem_q[wa_i];
  assign rd_o = mem_q[ra_i];

  // Overwrite on the first slice, accumulate on later ones.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wa_i] <= add_i ? opnd + wd_i : wd_i;
    end
  end
endmodule

// File: rtl/conv_psum_accum.sv
// Shift-add accumulator behind the PIM conv crossbar stage:
// folds IN_BITS bit-slices per column, then streams DEPTH sums.
module conv_psum_accum
  import conv_psum_accum_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADC_P   = ADC_P_DEF,
  parameter int IN_BITS = IN_BITS_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic clk,
  input  logic rst,
  conv_psum_accum_if.slave bus
);
  localparam int AW = clogb2(DEPTH);
  localparam int SW = clogb2(IN_BITS);

  if (ACC_W < ADC_P + IN_BITS) begin : g_accw_chk
    $error("ACC_W narrower than ADC_P+IN_BITS");
  end
  // The first drain word is read while the last beat is written.
  if (DEPTH < 2) begin : g_depth_chk
    $error("DEPTH must be at least 2");
  end

  state_e           state_q;
  logic [AW-1:0]    wr_addr_q;
  logic [SW-1:0]    slice_q;
  logic [AW-1:0]    rd_ptr_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_data_q;
  logic [AW-1:0]    out_addr_q;
  logic             done_q;
  logic             err_q;

  logic             beat;
  logic             last_addr;
  logic             last_slice;
  logic             last_rd;
  logic             accept;
  logic [ACC_W-1:0] shd;
  logic [AW-1:0]    rd_sel;
  logic [ACC_W-1:0] rd_data;

  assign beat       = (state_q == ST_ACCUM) && bus.in_valid;
  assign last_addr  = wr_addr_q == AW'(DEPTH - 1);
  assign last_slice = slice_q == SW'(IN_BITS - 1);
  assign last_rd    = rd_ptr_q == AW'(DEPTH - 1);
  assign accept     = out_valid_q && bus.out_ready;
  assign shd        = ACC_W'(bus.in_data) << slice_q;

  // Prefetch address: word 0 on entry, next word while draining.
  assign rd_sel = (state_q == ST_DRAIN && !last_rd)
                ? rd_ptr_q + 1'b1 : '0;

  conv_psum_accum_rf #(
    .DEPTH (DEPTH),
    .ACC_W (ACC_W),
    .AW    (AW)
  ) u_rf (
    .clk   (clk),
    .we_i  (beat),
    .add_i (slice_q != '0),
    .wa_i  (wr_addr_q),
    .wd_i  (shd),
    .ra_i  (rd_sel),
    .rd_o  (rd_data)
  );

  // Window FSM with its counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      slice_q     <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            wr_addr_q <= '0;
            slice_q   <= '0;
            err_q     <= 1'b0;
            state_q   <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (bus.in_valid) begin
            if (bus.in_addr != wr_addr_q) err_q <= 1'b1;
            if (last_addr) begin
              wr_addr_q <= '0;
              if (last_slice) begin
                state_q     <= ST_DRAIN;
                rd_ptr_q    <= '0;
                out_valid_q <= 1'b1;
                out_data_q  <= rd_data;
                out_addr_q  <= '0;
              end else begin
                slice_q <= slice_q + 1'b1;
              end
            end else begin
              wr_addr_q <= wr_addr_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (accept) begin
            if (last_rd) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              rd_ptr_q   <= rd_sel;
              out_data_q <= rd_data;
              out_addr_q <= rd_sel;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = state_q != ST_IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
